// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - mode/phase encodings and mode sequencing for the LED sequencing controller
package led_seq_pkg;

    localparam logic [1:0] MODE_SHL   = 2'd0;
    localparam logic [1:0] MODE_SHR   = 2'd1;
    localparam logic [1:0] MODE_FLASH = 2'd2;

    typedef enum logic {
        PH_RUN  = 1'b0,
        PH_SYNC = 1'b1
    } phase_t;

    // Encoding 3 is not a legal mode; it recovers to SHL.
    function automatic logic [1:0] next_mode(input logic [1:0] mode);
        case (mode)
            MODE_SHL:   next_mode = MODE_SHR;
            MODE_SHR:   next_mode = MODE_FLASH;
            MODE_FLASH: next_mode = MODE_SHL;
            default:    next_mode = MODE_SHL;
        endcase
    endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// rtl/led_tick_prescaler.sv - programmable time base; tick is high in the cycle the counter wraps
module led_tick_prescaler #(
    parameter int NB_CNT   = 32,
    parameter int LIM_BASE = 2**24
) (
    input  logic       clock,
    input  logic       i_reset,
    input  logic       run,
    input  logic       clear,
    input  logic [1:0] speed,
    output logic       tick
);

    logic [NB_CNT-1:0] cnt;
    logic [NB_CNT-1:0] lim_m1;

    assign lim_m1 = (NB_CNT'(LIM_BASE) << speed) - NB_CNT'(1);

    // >= rather than == so that lowering the speed mid-count wraps at once.
    assign tick = run && (cnt >= lim_m1);

    always_ff @(posedge clock) begin
        if (i_reset || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + NB_CNT'(1);
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - LED sequencing controller: mode FSM, button edge, tick routing, engine restart
// Optional auto mode cycling when LED_SEQ_AUTO_EN is defined.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int NB_CNT     = 32,
    parameter int LIM_BASE   = 2**24,
    parameter int AUTO_TICKS = 16
) (
    input  logic       clock,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic [1:0] i_speed,
    input  logic       i_mode_btn,
    input  logic       i_engine_valid,
    output logic       o_tick_shift,
    output logic       o_dir,
    output logic       o_tick_flash,
    output logic [1:0] o_mode,
    output logic       o_restart
);

    phase_t     phase, phase_nxt;
    logic [1:0] mode_nxt;
    logic       btn_d;
    logic       btn_rise;
    logic       wrap;
    logic       advance;
    logic       auto_adv;
    logic       restart_nxt;
    logic       tick_shift_nxt;
    logic       tick_flash_nxt;
    logic       dir_nxt;

    assign btn_rise = i_mode_btn && !btn_d;

    led_tick_prescaler #(
        .NB_CNT   (NB_CNT),
        .LIM_BASE (LIM_BASE)
    ) u_prescaler (
        .clock   (clock),
        .i_reset (i_reset),
        .run     (i_enable && (phase == PH_RUN)),
        .clear   (advance || (phase == PH_SYNC)),
        .speed   (i_speed),
        .tick    (wrap)
    );

`ifdef LED_SEQ_AUTO_EN
    localparam int NB_TC = $clog2(AUTO_TICKS + 1);

    logic [NB_TC-1:0] tick_cnt;

    // Fires in the cycle the last tick strobe is visible, so the mode moves one cycle later.
    assign auto_adv = (phase == PH_RUN) && (tick_cnt == NB_TC'(AUTO_TICKS));

    always_ff @(posedge clock) begin
        if (i_reset || restart_nxt) begin
            tick_cnt <= '0;
        end else if (wrap) begin
            tick_cnt <= tick_cnt + NB_TC'(1);
        end
    end
`else
    assign auto_adv = 1'b0;
`endif

    always_comb begin
        phase_nxt      = phase;
        mode_nxt       = (o_mode == 2'd3) ? MODE_SHL : o_mode;
        advance        = 1'b0;
        restart_nxt    = 1'b0;
        tick_shift_nxt = 1'b0;
        tick_flash_nxt = 1'b0;
        case (phase)
            PH_RUN: begin
                // A mode change takes priority over a coincident wrap; that tick is lost.
                if (btn_rise || auto_adv) begin
                    advance     = 1'b1;
                    mode_nxt    = next_mode(o_mode);
                    restart_nxt = 1'b1;
                    phase_nxt   = PH_SYNC;
                end else if (wrap) begin
                    tick_shift_nxt = (o_mode == MODE_SHL) || (o_mode == MODE_SHR);
                    tick_flash_nxt = (o_mode == MODE_FLASH);
                end
            end
            PH_SYNC: begin
                // Engine ready is only trusted from the cycle after the restart pulse.
                if (i_engine_valid && !o_restart) begin
                    phase_nxt = PH_RUN;
                end
            end
            default: phase_nxt = PH_RUN;
        endcase
        dir_nxt = (mode_nxt == MODE_SHR);
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            phase        <= PH_RUN;
            btn_d        <= 1'b0;
            o_mode       <= MODE_SHL;
            o_dir        <= 1'b0;
            o_restart    <= 1'b0;
            o_tick_shift <= 1'b0;
            o_tick_flash <= 1'b0;
        end else begin
            phase        <= phase_nxt;
            btn_d        <= i_mode_btn;
            o_mode       <= mode_nxt;
            o_dir        <= dir_nxt;
            o_restart    <= restart_nxt;
            o_tick_shift <= tick_shift_nxt;
            o_tick_flash <= tick_flash_nxt;
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - randomized bench for led_seq_ctrl against an in-bench reference model
module tb_led_seq_ctrl;

    localparam int LIM  = 4;
    localparam int AUTO = 3;

    logic       clock;
    logic       rst;
    logic       en;
    logic [1:0] spd;
    logic       btn;
    logic       valid;
    logic       o_tick_shift;
    logic       o_dir;
    logic       o_tick_flash;
    logic [1:0] o_mode;
    logic       o_restart;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    led_seq_ctrl #(
        .NB_CNT     (32),
        .LIM_BASE   (LIM),
        .AUTO_TICKS (AUTO)
    ) dut (
        .clock          (clock),
        .i_reset        (rst),
        .i_enable       (en),
        .i_speed        (spd),
        .i_mode_btn     (btn),
        .i_engine_valid (valid),
        .o_tick_shift   (o_tick_shift),
        .o_dir          (o_dir),
        .o_tick_flash   (o_tick_flash),
        .o_mode         (o_mode),
        .o_restart      (o_restart)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: mode index, whether engines are being restarted, cycles counted toward the next tick.
    int m_mode = 0;
    int m_sync = 0;
    int m_cnt  = 0;
    int m_prev = 0;
    int m_ticks = 0;
    int e_ts = 0, e_tf = 0, e_rs = 0;

    always @(posedge clock) begin
        int rise, was_rs, auto_go;
        #1;
        cyc++;
        if (rst) begin
            m_mode = 0; m_sync = 0; m_cnt = 0; m_prev = 0; m_ticks = 0;
            e_ts = 0; e_tf = 0; e_rs = 0;
        end else begin
            rise   = (btn && !m_prev) ? 1 : 0;
            m_prev = btn;
            was_rs = e_rs;
            e_ts = 0; e_tf = 0; e_rs = 0;
            auto_go = 0;
`ifdef LED_SEQ_AUTO_EN
            auto_go = (!m_sync && m_ticks == AUTO) ? 1 : 0;
`endif
            if (!m_sync) begin
                if (rise || auto_go) begin
                    m_mode = (m_mode + 1) % 3;
                    m_cnt = 0; m_sync = 1; e_rs = 1; m_ticks = 0;
                end else if (en) begin
                    if (m_cnt >= (LIM << spd) - 1) begin
                        m_cnt = 0;
                        m_ticks++;
                        if (m_mode == 2) e_tf = 1;
                        else e_ts = 1;
                    end else begin
                        m_cnt++;
                    end
                end
            end else if (valid && !was_rs) begin
                m_sync = 0;
            end
        end
        chk("model_mode", int'(o_mode), m_mode);
        chk("model_dir", int'(o_dir), (m_mode == 1) ? 1 : 0);
        chk("model_tick_shift", int'(o_tick_shift), e_ts);
        chk("model_tick_flash", int'(o_tick_flash), e_tf);
        chk("model_restart", int'(o_restart), e_rs);
    end

    task automatic wait_tick(input int want_flash, output int at);
        int found;
        found = 0;
        at = -1;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clock);
            if ((want_flash ? o_tick_flash : o_tick_shift) == 1'b1) begin
                found = 1;
                at = cyc;
            end
        end
        if (!found) chk("wait_tick_timeout", 0, 1);
    endtask

    task automatic press();
        btn = 1'b1;
        @(negedge clock);
        btn = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        int t1, t2, t3, t4, t5, t6, t7, t8, m;
        rst = 1'b1; en = 1'b0; spd = 2'd0; btn = 1'b0; valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_mode", int'(o_mode), 0);
        chk("reset_dir", int'(o_dir), 0);
        chk("reset_tick_shift", int'(o_tick_shift), 0);
        chk("reset_tick_flash", int'(o_tick_flash), 0);
        chk("reset_restart", int'(o_restart), 0);
        rst = 1'b0;
`ifndef LED_SEQ_AUTO_EN
        en = 1'b1;
        wait_tick(0, t1);
        wait_tick(0, t2);
        chk("period_spd0_a", t2 - t1, 4);
        wait_tick(0, t3);
        chk("period_spd0_b", t3 - t2, 4);
        spd = 2'd2;
        wait_tick(0, t4);
        chk("period_spd2_a", t4 - t3, 16);
        wait_tick(0, t5);
        chk("period_spd2_b", t5 - t4, 16);
        repeat (10) @(negedge clock);
        spd = 2'd0;
        wait_tick(0, t6);
        chk("speed_drop_wrap", t6 - t5, 11);
        wait_tick(0, t7);
        chk("speed_drop_period", t7 - t6, 4);

        btn = 1'b1;
        @(negedge clock);
        btn = 1'b0;
        chk("btn_mode_shr", int'(o_mode), 1);
        chk("btn_dir_right", int'(o_dir), 1);
        chk("btn_restart", int'(o_restart), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("sync_restart_low", int'(o_restart), 0);
            chk("sync_no_tick", int'(o_tick_shift), 0);
        end
        m = cyc;
        valid = 1'b1;
        wait_tick(0, t8);
        chk("resume_latency", t8 - m, 5);

        press();
        chk("mode_flash", int'(o_mode), 2);
        wait_tick(1, t1);
        chk("flash_not_shift", int'(o_tick_shift), 0);
        press();
        chk("mode_wrap_shl", int'(o_mode), 0);

        wait_tick(0, t1);
        repeat (3) @(negedge clock);
        valid = 1'b0;
        btn = 1'b1;
        @(negedge clock);
        chk("coincide_tick_dropped", int'(o_tick_shift), 0);
        chk("coincide_restart", int'(o_restart), 1);
        btn = 1'b0;
        @(negedge clock);
        btn = 1'b1;
        repeat (2) @(negedge clock);
        chk("sync_edge_ignored", int'(o_mode), 1);
        btn = 1'b0;
        valid = 1'b1;
        repeat (3) @(negedge clock);
`endif
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            rst   = ($urandom_range(0, 499) == 0);
            en    = ($urandom_range(0, 9) != 0);
            valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 63) == 0) spd = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) btn = ~btn;
        end
        rst = 1'b0;
        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
